// File: rtl/matrix_div_pkg.sv
// rtl/matrix_div_pkg.sv - shared widths, FSM states and element helpers for the matrix division sequencer
package matrix_div_pkg;

    localparam int W      = 16;
    localparam int N_ELEM = 9;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
    typedef logic [3:0] idx_t;

    // Quotient written for a skipped divide-by-zero element.
    localparam logic [W-1:0] DIVZERO_FILL = {W{1'b1}};

    function automatic logic [N_ELEM*W-1:0] put_elem(input logic [N_ELEM*W-1:0] mat,
                                                     input idx_t k,
                                                     input logic [W-1:0] e);
        logic [N_ELEM*W-1:0] r;
        r = mat;
        for (int j = 0; j < N_ELEM; j++) begin
            if (idx_t'(j) == k) r[j*W +: W] = e;
        end
        return r;
    endfunction

    function automatic logic [N_ELEM-1:0] elem_bit(input idx_t k);
        logic [N_ELEM-1:0] r;
        r = '0;
        for (int j = 0; j < N_ELEM; j++) begin
            if (idx_t'(j) == k) r[j] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_div_elem_sel.sv
// rtl/matrix_div_elem_sel.sv - combinational 9:1 element selector over a flat latched matrix
module matrix_div_elem_sel
    import matrix_div_pkg::*;
(
    input  logic [N_ELEM*W-1:0] mat,
    input  idx_t                idx,
    output logic [W-1:0]        elem
);

    always_comb begin
        elem = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (idx == idx_t'(k)) elem = mat[k*W +: W];
        end
    end

endmodule

// File: rtl/matrix_division_sequencer.sv
// rtl/matrix_division_sequencer.sv - time-shares one divider over 3x3 element pairs; option DIVZERO_SKIP_EN
module matrix_division_sequencer
    import matrix_div_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_ELEM*W-1:0] mat_a,
    input  logic [N_ELEM*W-1:0] mat_b,
    output logic                busy,
    output logic                done,
    output logic [N_ELEM*W-1:0] result,
    output logic [N_ELEM-1:0]   err_mask,
    output logic                div_start,
    output logic [W-1:0]        div_dividend,
    output logic [W-1:0]        div_divisor,
    input  logic                div_valid,
    input  logic [W-1:0]        div_quotient
);

    localparam int TW = $clog2(TIMEOUT);

    state_t              state, state_nx;
    idx_t                idx;
    logic [TW-1:0]       timer;
    logic [N_ELEM*W-1:0] lat_a, lat_b;
    logic                timed_out, divzero;

    // Operands come straight from the latched copies, so they hold while idx is parked in WAIT.
    matrix_div_elem_sel u_sel_a (.mat(lat_a), .idx(idx), .elem(div_dividend));
    matrix_div_elem_sel u_sel_b (.mat(lat_b), .idx(idx), .elem(div_divisor));

    assign timed_out = (timer == TW'(TIMEOUT - 1));
`ifdef DIVZERO_SKIP_EN
    assign divzero = (div_divisor == '0);
`else
    assign divzero = 1'b0;
`endif

    assign busy = (state == ISSUE) || (state == WAIT) || (state == NEXT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: begin
                if (divzero) begin
                    state_nx = NEXT;
                end else begin
                    div_start = 1'b1;
                    state_nx  = WAIT;
                end
            end
            WAIT:  if (div_valid || timed_out) state_nx = NEXT;
            NEXT:  state_nx = (idx == idx_t'(N_ELEM - 1)) ? DONE : ISSUE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            timer    <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            result   <= '0;
            err_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_a    <= mat_a;
                        lat_b    <= mat_b;
                        err_mask <= '0;
                        idx      <= '0;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    if (divzero) begin
                        result   <= put_elem(result, idx, DIVZERO_FILL);
                        err_mask <= err_mask | elem_bit(idx);
                    end
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A strobe arriving on the timeout cycle still delivers its quotient.
                    if (div_valid) begin
                        result <= put_elem(result, idx, div_quotient);
                    end else if (timed_out) begin
                        result   <= put_elem(result, idx, W'(0));
                        err_mask <= err_mask | elem_bit(idx);
                    end
                end
                NEXT: if (idx != idx_t'(N_ELEM - 1)) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_division_sequencer.sv
// tb/tb_matrix_division_sequencer.sv - directed vector bench with a behavioural divider model
module tb_matrix_division_sequencer;

    localparam int W  = 16;
    localparam int NE = 9;
    localparam logic [W-1:0] DIV0_Q = 16'hDEAD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NE*W-1:0] mat_a, mat_b;
    logic            busy, done;
    logic [NE*W-1:0] result;
    logic [NE-1:0]   err_mask;
    logic            div_start;
    logic [W-1:0]    div_dividend, div_divisor;
    logic            div_valid;
    logic [W-1:0]    div_quotient;

    matrix_division_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mat_a(mat_a), .mat_b(mat_b),
        .busy(busy), .done(done), .result(result), .err_mask(err_mask),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid(div_valid), .div_quotient(div_quotient)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [NE*W-1:0] act, input logic [NE*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NE*W-1:0] mk(input int e0, input int e1, input int e2,
                                           input int e3, input int e4, input int e5,
                                           input int e6, input int e7, input int e8);
        return {W'(e8), W'(e7), W'(e6), W'(e5), W'(e4), W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    // Divider model: answers after lat_rand ? 1..10 : 1 cycles, never for element number hang_elem.
    int           lat_rand = 0;
    int           hang_elem = -1;
    int           n_starts = 0;
    int           stab_bad = 0;
    int           done_cnt = 0;
    bit           pending = 0;
    bit           hang = 0;
    int           cnt = 0;
    logic [W-1:0] cap_a, cap_b;

    initial begin
        div_valid    = 1'b0;
        div_quotient = '0;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst_n) begin
            pending   = 0;
            div_valid = 1'b0;
        end else begin
            if (div_valid) begin
                div_valid = 1'b0;
                pending   = 0;
            end
            if (div_start) begin
                hang    = (n_starts == hang_elem);
                n_starts++;
                pending = 1;
                cap_a   = div_dividend;
                cap_b   = div_divisor;
                cnt     = (lat_rand != 0) ? int'($urandom_range(1, 10)) : 1;
            end else if (pending) begin
                if (div_dividend !== cap_a || div_divisor !== cap_b) stab_bad++;
                if (!hang) begin
                    cnt--;
                    if (cnt == 0) begin
                        div_valid    = 1'b1;
                        div_quotient = (cap_b == 0) ? DIV0_Q : cap_a / cap_b;
                    end
                end
            end
        end
    end

    typedef struct {
        string           name;
        logic [NE*W-1:0] a;
        logic [NE*W-1:0] b;
        int              lat_rand;
        int              hang;
        logic [NE*W-1:0] exp_res;
        logic [NE-1:0]   exp_err;
        int              exp_pulses;
        int              exp_lat;
    } vec_t;

    // Cycles are counted inclusively from the cycle start is high to the cycle done is high.
    int lat_meas;

    task automatic launch(input logic [NE*W-1:0] a, input logic [NE*W-1:0] b);
        n_starts = 0;
        stab_bad = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat_meas = 2;
    endtask

    task automatic wait_done(input string nm);
        bit got = 0;
        while (!got && lat_meas < 400) begin
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
                lat_meas++;
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", nm);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input vec_t v);
        chk({v.name, "_result"}, result, v.exp_res);
        chk({v.name, "_err_mask"}, NE*W'(err_mask), NE*W'(v.exp_err));
        chk({v.name, "_div_starts"}, NE*W'(n_starts), NE*W'(v.exp_pulses));
        chk({v.name, "_done_pulses"}, NE*W'(done_cnt), NE*W'(1));
        chk({v.name, "_operand_stable"}, NE*W'(stab_bad), '0);
        if (v.exp_lat != 0) chk({v.name, "_latency"}, NE*W'(lat_meas), NE*W'(v.exp_lat));
    endtask

    vec_t vecs[5];
    logic [NE*W-1:0] basic_a, basic_b, basic_q, dz_b;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mat_a = '0;
        mat_b = '0;

        basic_a = mk(128, 16, 128, 8, 2, 1, 2, 16, 2);
        basic_b = mk(4, 2, 1, 1, 1, 32, 4, 512, 2);
        basic_q = mk(32, 8, 128, 8, 2, 0, 0, 0, 1);
        dz_b    = mk(4, 2, 0, 1, 1, 32, 4, 512, 2);

        vecs[0] = '{"basic", basic_a, basic_b, 0, -1, basic_q, 9'b0, 9, 29};
        vecs[1] = '{"varlat", basic_a, basic_b, 1, -1, basic_q, 9'b0, 9, 0};
        vecs[2] = '{"timeout", basic_a, basic_b, 0, 4,
                    mk(32, 8, 128, 8, 0, 0, 0, 0, 1), 9'b000010000, 9, 92};
`ifdef DIVZERO_SKIP_EN
        vecs[3] = '{"divzero", basic_a, dz_b, 0, -1,
                    mk(32, 8, 16'hFFFF, 8, 2, 0, 0, 0, 1), 9'b000000100, 8, 28};
`else
        vecs[3] = '{"divzero", basic_a, dz_b, 0, -1,
                    mk(32, 8, DIV0_Q, 8, 2, 0, 0, 0, 1), 9'b0, 9, 29};
`endif
        vecs[4] = '{"wide", mk(65535, 1000, 7, 0, 300, 65535, 12345, 9, 50),
                    mk(1, 10, 2, 5, 301, 65535, 100, 3, 7),
                    0, -1, mk(65535, 100, 3, 0, 0, 1, 123, 3, 7), 9'b0, 9, 29};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_done", NE*W'({busy, done, div_start}), '0);
        chk("reset_result", result, '0);
        chk("reset_err_operands", NE*W'({err_mask, div_dividend, div_divisor}), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            lat_rand  = vecs[i].lat_rand;
            hang_elem = vecs[i].hang;
            launch(vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name);
            check_run(vecs[i]);
        end

        // Start pulse and operand change while element 3 is in flight must be ignored.
        lat_rand  = 0;
        hang_elem = -1;
        launch(basic_a, basic_b);
        while (n_starts < 4 && lat_meas < 200) begin
            @(posedge clk); #1;
            lat_meas++;
        end
        chk("busy_mid_run", NE*W'(busy), NE*W'(1));
        start = 1'b1;
        mat_a = mk(7, 7, 7, 7, 7, 7, 7, 7, 7);
        @(posedge clk); #1;
        lat_meas++;
        start = 1'b0;
        wait_done("restart");
        check_run(vecs[0]);

        // Asynchronous reset while element 5 is waiting on a silent divider.
        hang_elem = 5;
        launch(basic_a, basic_b);
        while (n_starts < 6 && lat_meas < 200) begin
            @(posedge clk); #1;
            lat_meas++;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy_done_start", NE*W'({busy, done, div_start}), '0);
        chk("midreset_result", result, '0);
        chk("midreset_err_operands", NE*W'({err_mask, div_dividend, div_divisor}), '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_no_done", NE*W'(done_cnt), '0);

        hang_elem = -1;
        launch(basic_a, basic_b);
        wait_done("after_reset");
        check_run(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_division_sequencer.md
Name: matrix_division_sequencer

Overview:
Sequences a single shared 16-bit divider unit across all nine element pairs of two 3x3 matrices. It produces the element-wise quotient matrix that the fully parallel matrix_division datapath computes in one pass, at a fraction of the area. It sits between the matrix operand registers and one divider instance, which it drives over a start/valid handshake. The quotient matrix is presented on a flat bus with a one-cycle done pulse.

Parameters:
W, 16, element width in bits
N_ELEM, 9, elements per matrix; element k order is a,b,c,d,e,f,g,h,i for k=0..8
TIMEOUT, 64, maximum cycles to wait for div_valid before the element is aborted

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a matrix division; sampled only in IDLE
mat_a  in  N_ELEM*W  dividend matrix; element k at [k*W+W-1:k*W], element bit 0 = LSB
mat_b  in  N_ELEM*W  divisor matrix; same packing as mat_a
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when all N_ELEM quotients are written
result  out  N_ELEM*W  quotient matrix; same packing as mat_a
err_mask  out  N_ELEM  bit k set when element k timed out (or was divide-by-zero with the option enabled)
div_start  out  1  one-cycle request to the divider
div_dividend  out  W  operand for the divider; stable from div_start until div_valid
div_divisor  out  W  operand for the divider; stable from div_start until div_valid
div_valid  in  1  divider result strobe
div_quotient  in  W  divider result; sampled when div_valid=1

Behaviour:
- Reset (asynchronous on rst_n low): state=IDLE, idx=0, timer=0. busy=0, done=0, div_start=0, div_dividend=0, div_divisor=0, result=0, err_mask=0.
- Operand capture: on an accepted start, mat_a and mat_b are latched into internal copies. Later changes on the inputs have no effect on the run in progress.
- IDLE: start=1 latches operands, clears err_mask, sets idx=0 -> ISSUE. result keeps its previous values until each element is overwritten.
- ISSUE: drives div_start=1 for exactly one cycle and loads div_dividend/div_divisor with element idx. Clears timer. -> WAIT.
- WAIT: each cycle, timer increments.
  - div_valid=1: result[idx] <= div_quotient -> NEXT.
  - timer reaches TIMEOUT-1 with no div_valid: result[idx] <= 0, err_mask[idx] <= 1 -> NEXT.
  - div_valid and timeout in the same cycle: div_valid wins.
- NEXT: if idx==N_ELEM-1 -> DONE; otherwise idx <= idx+1 -> ISSUE.
- DONE: done=1 for one cycle -> IDLE. busy drops in the same cycle done rises.
- Latency: 3 cycles per element minimum when div_valid arrives in the first WAIT cycle, giving a best case of 27 + 2 cycles from start to done.
- start while busy is ignored, with no queuing.
- div_valid outside WAIT is ignored.
- div_quotient is passed through unmodified; no width change.
- Reset mid-run aborts immediately: result is cleared and no done pulse is produced.

Optional Feature:
DIVZERO_SKIP_EN
- Defined: in ISSUE, a divisor of element idx equal to 0 skips the divider. No div_start is issued, result[idx] <= {W{1'b1}}, err_mask[idx] <= 1, and the FSM goes directly to NEXT.
- Undefined: zero divisors are issued to the divider like any other element. err_mask is set only on timeout.

Decomposition:
- Package matrix_div_pkg holds W, N_ELEM, the state enum (IDLE, ISSUE, WAIT, NEXT, DONE), the element index type (4 bits), and the DIVZERO_FILL constant.
- Sub-module matrix_div_elem_sel: combinational 9:1 W-bit selector from the latched matrices by idx, shared by the dividend and divisor paths.

Test Plan:
- Basic run, with a single-cycle-latency divider model:
  - Stimulus: mat_a=(128,16,128,8,2,1,2,16,2), mat_b=(4,2,1,1,1,32,4,512,2).
  - Required: result=(32,8,128,8,2,0,0,0,1), err_mask=0, done exactly 29 cycles after start, 9 div_start pulses.
- Variable-latency divider (1..10 cycles, random): same operands -> identical result; operands stable between each div_start and div_valid.
- Timeout: divider never answers for element 4 -> result[4]=0, err_mask=9'b000010000, other elements correct, done still asserted.
- Divide-by-zero, mat_b element 2 = 0:
  - With DIVZERO_SKIP_EN: result[2]=16'hFFFF, err_mask[2]=1, only 8 div_start pulses.
  - Without DIVZERO_SKIP_EN: 9 pulses, result[2]=divider output.
- Start while busy, and input change mid-run: start pulsed at element 3 plus mat_a changed -> ignored; result matches the original operands; exactly one done pulse.
- Async reset mid-run: rst_n low during WAIT of element 5 -> all outputs 0 immediately, no done pulse; a fresh start then completes normally.
